// File: rtl/tinker_pkg.sv
// tinker_pkg: shared widths, reset PC, fetch queue entry and fetch state types
package tinker_pkg;
  localparam int XLEN = 64;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h2000;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc4;
  } fetch_entry_t;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/tinker_sync_fifo.sv
// tinker_sync_fifo: synchronous FIFO with flush; simultaneous push and pop allowed when full
module tinker_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: PC generation, credit-limited instruction reads, prefetch queue to IF/ID,
// and redirect handling that discards responses of requests granted before the redirect.
module tinker_fetch_unit
  import tinker_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int QDEPTH = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [63:0]     redirect_pc,
  output logic            imem_req,
  output logic [63:0]     imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [63:0]     id_pc4,
  output logic            busy
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  logic [XLEN-1:0] fetch_pc, af_dout;
  logic [OW-1:0] outstanding, drop_cnt, drop_next;
  logic [CW-1:0] q_count;
  fetch_state_t state, state_next;
  fetch_entry_t q_din, q_dout;
  logic q_full, q_empty, af_full, af_empty, credit, grant, push_q, pop_q, dropping;
  // Counting queued plus in-flight words against QDEPTH guarantees every response has a slot.
  assign credit = (CW + 1)'(q_count) + (CW + 1)'(outstanding) < (CW + 1)'(QDEPTH);
  assign imem_req = ~reset & fetch_en & ~redirect_valid & credit & ~af_full;
  assign imem_addr = fetch_pc;
  assign grant = imem_req & imem_gnt;
  assign dropping = state == DRAIN;
  assign push_q = imem_rvalid & ~dropping & ~redirect_valid;
  assign pop_q = id_valid & id_ready;
  assign q_din = '{instr: imem_rdata, pc4: af_dout + 64'd4};
  assign id_valid = ~q_empty;
  assign id_instr = id_valid ? q_dout.instr : '0;
  assign id_pc4 = id_valid ? q_dout.pc4 : '0;
  assign busy = (outstanding != '0) | ~q_empty;
  // On redirect every in-flight request is stale, except one retiring this very cycle.
  always_comb begin
    drop_next = redirect_valid ? outstanding - OW'(imem_rvalid) : drop_cnt - OW'(imem_rvalid & dropping);
    state_next = (drop_next != '0) ? DRAIN : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      state <= RUN;
    end else begin
      fetch_pc <= redirect_valid ? {redirect_pc[63:2], 2'b00} : grant ? fetch_pc + 64'd4 : fetch_pc;
      drop_cnt <= drop_next;
      state <= state_next;
    end
  end
  tinker_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk(clk), .reset(reset), .push(push_q), .pop(pop_q), .flush(redirect_valid),
    .din(q_din), .dout(q_dout), .count(q_count), .full(q_full), .empty(q_empty)
  );
  // In-flight addresses are never flushed: they pair with responses purely by order.
  tinker_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_inflight (
    .clk(clk), .reset(reset), .push(grant), .pop(imem_rvalid), .flush(1'b0),
    .din(fetch_pc), .dout(af_dout), .count(outstanding), .full(af_full), .empty(af_empty)
  );
  a_redirect_aligned: assert property (@(posedge clk) disable iff (reset)
    redirect_valid |-> redirect_pc[1:0] == 2'b00);
  a_rvalid_legal: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> !af_empty && !q_full);
endmodule

// File: tb/tb_tinker_fetch_unit.sv
// tb_tinker_fetch_unit: table-driven and directed checks of the fetch unit against a latency-configurable memory.
module tb_tinker_fetch_unit;
  import tinker_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, id_valid, busy;
  logic [63:0] imem_addr, id_pc4;
  logic [31:0] id_instr;
  always #5 clk = ~clk;
  tinker_fetch_unit #(.RESET_PC(64'h2000), .QDEPTH(4), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc4(id_pc4), .busy(busy)
  );
  int errors = 0, checks = 0;
  int gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;
  int unsigned cyc = 0;
  typedef struct {logic [63:0] addr; int unsigned due;} pend_t;
  pend_t pend[$];
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'h1111_1111 * ((a[31:0] >> 2) - 32'h7FF);
  endfunction
  // Memory model: in-order responses, at least one cycle after grant.
  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      pend.delete();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
        imem_rvalid = 1'b1;
        imem_rdata = instr_of(pend[0].addr);
        pend.delete(0);
      end
      imem_gnt = $urandom_range(0, 99) < gnt_pct;
      if (imem_req && imem_gnt)
        pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
    end
    cyc++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic e, input logic d, input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    reset = r;
    fetch_en = e;
    id_ready = d;
    redirect_valid = rv;
    redirect_pc = rpc;
    #3;
  endtask
  task automatic expect_next(input logic e, input logic [63:0] pc4, input int limit);
    for (int i = 0; i < limit; i++) begin
      drive(1'b0, e, 1'b1, 1'b0, 64'h0);
      if (id_valid) begin
        check("next pc4", id_pc4, pc4);
        check("next instr", 64'(id_instr), 64'(instr_of(pc4 - 64'd4)));
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL next word timeout: got none, want pc4 0x%0h", pc4);
  endtask
  typedef struct {
    logic rst, en, rdy, req;
    logic [63:0] addr;
    logic vld;
    logic [63:0] pc4;
    logic bsy;
  } vec_t;
  vec_t vecs[23];
  logic rv;
  logic [63:0] rpc, exp_pc;
  int delivered;
  initial begin
    vecs = '{
      '{1'b1, 1'b1, 1'b1, 1'b0, 64'h2000, 1'b0, 64'h0,    1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h0,    1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2004, 1'b0, 64'h0,    1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2008, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h200C, 1'b1, 64'h2008, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2010, 1'b1, 64'h200C, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 64'h2014, 1'b1, 64'h2010, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 64'h2000, 1'b0, 64'h0,    1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h0,    1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 64'h2004, 1'b0, 64'h0,    1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 64'h2008, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 64'h200C, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 64'h2010, 1'b1, 64'h2004, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2010, 1'b1, 64'h2008, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2014, 1'b1, 64'h200C, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2018, 1'b1, 64'h2010, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 64'h201C, 1'b1, 64'h2014, 1'b1}
    };
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    // 1-cycle memory: streaming fill, mid-run reset, then a 10-cycle decode stall.
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rdy, 1'b0, 64'h0);
      check($sformatf("vec%0d imem_req", i), 64'(imem_req), 64'(vecs[i].req));
      check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("vec%0d id_valid", i), 64'(id_valid), 64'(vecs[i].vld));
      check($sformatf("vec%0d id_pc4", i), id_pc4, vecs[i].pc4);
      check($sformatf("vec%0d id_instr", i), 64'(id_instr), vecs[i].vld ? 64'(instr_of(vecs[i].pc4 - 64'd4)) : 64'h0);
      check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].bsy));
    end
    // 3-cycle memory, redirect with three requests in flight.
    lat_min = 3;
    lat_max = 3;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h3000);
    check("redir3 no issue", 64'(imem_req), 64'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    check("redir3 new addr", imem_addr, 64'h3000);
    check("redir3 new req", 64'(imem_req), 64'h1);
    expect_next(1'b1, 64'h3004, 20);
    expect_next(1'b1, 64'h3008, 5);
    // Redirect coinciding with a response and a pop.
    lat_min = 1;
    lat_max = 1;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (4) drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h5000);
    check("redir4 pop valid", 64'(id_valid), 64'h1);
    check("redir4 no issue", 64'(imem_req), 64'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    check("redir4 queue empty", 64'(id_valid), 64'h0);
    check("redir4 busy", 64'(busy), 64'h0);
    check("redir4 addr", imem_addr, 64'h5000);
    check("redir4 req", 64'(imem_req), 64'h1);
    expect_next(1'b1, 64'h5004, 10);
    // Halt with two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      check($sformatf("halt%0d req", i), 64'(imem_req), 64'h0);
    end
    check("halt busy", 64'(busy), 64'h1);
    check("halt head pc4", id_pc4, 64'h2004);
    expect_next(1'b0, 64'h2004, 3);
    expect_next(1'b0, 64'h2008, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    check("halt idle busy", 64'(busy), 64'h0);
    check("halt idle valid", 64'(id_valid), 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h6000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("halt redir addr", imem_addr, 64'h6000);
    check("halt redir req", 64'(imem_req), 64'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    check("halt resume req", 64'(imem_req), 64'h1);
    check("halt resume addr", imem_addr, 64'h6000);
    // Random grant/response/ready/redirect against an in-order PC reference.
    gnt_pct = 70;
    rv_pct = 75;
    lat_min = 1;
    lat_max = 4;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    exp_pc = 64'h2000;
    delivered = 0;
    for (int i = 0; i < 10000; i++) begin
      rv = $urandom_range(0, 63) == 0;
      rpc = 64'h4000 + 64'($urandom_range(0, 1023)) * 64'd4;
      drive(1'b0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, rv, rpc);
      if (id_valid && id_ready) begin
        check($sformatf("rand%0d pc4", i), id_pc4, exp_pc + 64'd4);
        check($sformatf("rand%0d instr", i), 64'(id_instr), 64'(instr_of(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      if (rv) exp_pc = rpc;
    end
    check("rand progress", 64'(delivered > 500), 64'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
